fir_coeff_load_ctrl: RTL and testbench

//  Sequencer for the 33-tap direct-form FIR. Owns the coefficient SRAM write port and the filter enables.

---
 rtl/fir_ctrl_pkg.sv | 27 ++
 rtl/fir_sample_en_pipe.sv | 41 ++++
 rtl/fir_coeff_load_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_fir_coeff_load_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared definitions for the FIR coefficient load controller:
//   - default geometry of the 33-tap filter (taps, address/data/drop widths)
//   - controller state encoding (also exported on the debug state port)
//   - idle levels of the active-low SRAM control strobes
// ---------------------------------------------------------------------------
package fir_ctrl_pkg;

    localparam int NUM_TAPS_DEF = 33;
    localparam int ADDR_W_DEF   = 6;
    localparam int DATA_W_DEF   = 16;
    localparam int DROP_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RUN    = 2'd3
    } fir_state_e;

    // SRAM strobes are active-low; these are the levels driven whenever no
    // write is being issued.
    localparam logic RAM_CSN_IDLE = 1'b1;
    localparam logic RAM_WRN_IDLE = 1'b1;

endpackage

// File: rtl/fir_sample_en_pipe.sv
// ---------------------------------------------------------------------------
// fir_sample_en_pipe
// Two-stage enable pipe: a qualified sample at cycle t produces a one-cycle
// delay-line enable at t+1 and a one-cycle accumulate enable at t+2.
// A synchronous flush suppresses both the incoming sample and any pulse
// already in flight, so no enable escapes once the filter stops running.
//
// Ports
//   i_clk       clock
//   i_rst       asynchronous active-high reset
//   i_sample    sample qualified for processing this cycle
//   i_flush     drop the incoming sample and all pending pulses
//   o_en_delay  shift the sample delay line (registered)
//   o_en_acc    accumulate / update the filter output (registered)
// ---------------------------------------------------------------------------
module fir_sample_en_pipe (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample,
    input  logic i_flush,
    output logic o_en_delay,
    output logic o_en_acc
);

    logic r_en_delay;
    logic r_en_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en_delay <= 1'b0;
            r_en_acc   <= 1'b0;
        end else begin
            r_en_delay <= i_sample & ~i_flush;
            r_en_acc   <= r_en_delay & ~i_flush;
        end
    end

    assign o_en_delay = r_en_delay;
    assign o_en_acc   = r_en_acc;

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coeff_load_ctrl
// Sequencer for the 33-tap direct-form FIR. Loads a coefficient set from a
// host stream into the coefficient SRAM, commits it, and only then lets the
// filter run. A rising edge on the update flag starts a reload (preempting a
// running filter); dropping the flag before the set is complete abandons it.
// Samples arriving while the filter is not running are counted (saturating).
//
// Coefficient handshake: a coefficient is transferred in every cycle where
// iCoeffValid and oCoeffReady are both high at the clock edge; the host must
// hold iCoeffData stable while iCoeffValid is high and oCoeffReady is low.
//
// Ports
//   iClk_12M           12 MHz system clock
//   iRst               asynchronous active-high reset
//   iCoeffiUpdateFlag  level; rising edge requests a reload, low aborts a load
//   iCoeffValid        host coefficient valid
//   iCoeffData         host coefficient (signed), tap order 0..NUM_TAPS-1
//   oCoeffReady        controller accepts a coefficient
//   iSampleValid       a new filter input sample is present
//   oCsnRam            SRAM chip select, active-low
//   oWrnRam            SRAM write enable, active-low
//   oAddrRam           SRAM address (holds last value between writes)
//   oWrDtRam           SRAM write data (holds last value between writes)
//   oEnDelay           shift the sample delay line
//   oEnAcc             accumulate / update the filter output
//   oCoeffLoaded       a complete coefficient set is in SRAM
//   oUpdateDone        one-cycle pulse when a set is committed
//   oUpdateAbort       one-cycle pulse when a reload is abandoned
//   oDropCnt           samples ignored while not running, saturating
//   oDbgState          current controller state (fir_state_e encoding)
// ---------------------------------------------------------------------------
module fir_coeff_load_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DROP_W   = DROP_W_DEF
) (
    input  logic              iClk_12M,
    input  logic              iRst,
    input  logic              iCoeffiUpdateFlag,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    input  logic              iSampleValid,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic              oEnDelay,
    output logic              oEnAcc,
    output logic              oCoeffLoaded,
    output logic              oUpdateDone,
    output logic              oUpdateAbort,
    output logic [DROP_W-1:0] oDropCnt,
    output logic [1:0]        oDbgState
);

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    fir_state_e        r_state;
    logic [ADDR_W-1:0] r_tap_cnt;
    logic              r_flag_q;
    logic              r_coeff_ready;
    logic              r_csn;
    logic              r_wrn;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_loaded;
    logic              r_done;
    logic              r_abort;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_start;
    logic w_accept;
    logic w_last_tap;
    logic w_run;
    logic w_pipe_sample;
    logic w_pipe_flush;

    assign w_start    = iCoeffiUpdateFlag & ~r_flag_q;
    assign w_accept   = iCoeffValid & r_coeff_ready & (r_state == ST_LOAD);
    assign w_last_tap = (r_tap_cnt == LAST_TAP);
    assign w_run      = (r_state == ST_RUN);

    // A RUN cycle that also sees a reload request is the last RUN cycle:
    // flushing there keeps every enable pulse inside RUN.
    assign w_pipe_sample = iSampleValid & w_run;
    assign w_pipe_flush  = ~w_run | w_start;

    // Controller FSM with registered outputs.
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            r_state       <= ST_IDLE;
            r_tap_cnt     <= '0;
            r_flag_q      <= 1'b0;
            r_coeff_ready <= 1'b0;
            r_csn         <= RAM_CSN_IDLE;
            r_wrn         <= RAM_WRN_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_loaded      <= 1'b0;
            r_done        <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_flag_q <= iCoeffiUpdateFlag;
            // Strobes and pulses default to idle; address/data hold.
            r_csn    <= RAM_CSN_IDLE;
            r_wrn    <= RAM_WRN_IDLE;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state       <= ST_LOAD;
                        r_tap_cnt     <= '0;
                        r_coeff_ready <= 1'b1;
                        r_loaded      <= 1'b0;
                    end else if (r_loaded) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        r_csn   <= 1'b0;
                        r_wrn   <= 1'b0;
                        r_addr  <= r_tap_cnt;
                        r_wdata <= iCoeffData;
                    end
                    // The final accept takes priority over a falling flag.
                    if (w_accept && w_last_tap) begin
                        r_state       <= ST_COMMIT;
                        r_coeff_ready <= 1'b0;
                    end else if (!iCoeffiUpdateFlag) begin
                        r_state       <= ST_IDLE;
                        r_coeff_ready <= 1'b0;
                        r_abort       <= 1'b1;
                        r_loaded      <= 1'b0;
                    end else if (w_accept) begin
                        // Stops at LAST_TAP, so the counter never wraps.
                        r_tap_cnt <= r_tap_cnt + 1'b1;
                    end
                end

                ST_COMMIT: begin
                    // The last SRAM write is on the bus during this cycle.
                    r_state  <= ST_RUN;
                    r_loaded <= 1'b1;
                    r_done   <= 1'b1;
                end

                ST_RUN: begin
                    if (w_start) begin
                        r_state       <= ST_LOAD;
                        r_tap_cnt     <= '0;
                        r_coeff_ready <= 1'b1;
                        r_loaded      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Dropped-sample counter; cleared only by reset.
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            r_drop_cnt <= '0;
        end else if (iSampleValid && !w_run && (r_drop_cnt != DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    fir_sample_en_pipe u_en_pipe (
        .i_clk      (iClk_12M),
        .i_rst      (iRst),
        .i_sample   (w_pipe_sample),
        .i_flush    (w_pipe_flush),
        .o_en_delay (oEnDelay),
        .o_en_acc   (oEnAcc)
    );

    assign oCoeffReady  = r_coeff_ready;
    assign oCsnRam      = r_csn;
    assign oWrnRam      = r_wrn;
    assign oAddrRam     = r_addr;
    assign oWrDtRam     = r_wdata;
    assign oCoeffLoaded = r_loaded;
    assign oUpdateDone  = r_done;
    assign oUpdateAbort = r_abort;
    assign oDropCnt     = r_drop_cnt;
    assign oDbgState    = r_state;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_load_ctrl
// Drivers issue coefficient loads and samples; each issued item pushes its
// expected response (SRAM write, enable cycles, done/abort event) into a
// queue. A negedge monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_coeff_load_ctrl;
    import fir_ctrl_pkg::*;

    localparam int NUM_TAPS = 33;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;
    localparam logic [1:0] EV_DONE  = 2'b01;
    localparam logic [1:0] EV_ABORT = 2'b10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #42 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              flag = 1'b0;
    logic              cvalid = 1'b0;
    logic [DATA_W-1:0] cdata = '0;
    logic              sample = 1'b0;
    logic              coeff_ready, csn, wrn, en_delay, en_acc;
    logic              loaded, upd_done, upd_abort;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DROP_W-1:0] drop_cnt;
    logic [1:0]        dbg_state;

    fir_coeff_load_ctrl dut (
        .iClk_12M          (clk),
        .iRst              (rst),
        .iCoeffiUpdateFlag (flag),
        .iCoeffValid       (cvalid),
        .iCoeffData        (cdata),
        .oCoeffReady       (coeff_ready),
        .iSampleValid      (sample),
        .oCsnRam           (csn),
        .oWrnRam           (wrn),
        .oAddrRam          (addr),
        .oWrDtRam          (wdata),
        .oEnDelay          (en_delay),
        .oEnAcc            (en_acc),
        .oCoeffLoaded      (loaded),
        .oUpdateDone       (upd_done),
        .oUpdateAbort      (upd_abort),
        .oDropCnt          (drop_cnt),
        .oDbgState         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
    int                       exp_dly_q[$];
    int                       exp_acc_q[$];
    logic [1:0]               exp_ev_q[$];
    int errors = 0;
    int checks = 0;
    int drop_exp = 0;
    bit in_run = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void flag_error(string name, int info);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected/missing output, ref %0d, cycle %0d", name, info, cyc);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (!csn || !wrn) begin
                if (exp_wr_q.size() == 0) flag_error("sram_wr_unexpected", int'(addr));
                else begin
                    check("sram_strobes", 64'({csn, wrn}), 64'(2'b00));
                    check("sram_wr_addr_data", 64'({addr, wdata}), 64'(exp_wr_q.pop_front()));
                end
            end
            if (en_delay) begin
                if (exp_dly_q.size() == 0) flag_error("en_delay_unexpected", cyc);
                else check("en_delay_cycle", 64'(cyc), 64'(exp_dly_q.pop_front()));
            end
            while (exp_dly_q.size() > 0 && exp_dly_q[0] < cyc)
                flag_error("en_delay_missed", exp_dly_q.pop_front());
            if (en_acc) begin
                if (exp_acc_q.size() == 0) flag_error("en_acc_unexpected", cyc);
                else check("en_acc_cycle", 64'(cyc), 64'(exp_acc_q.pop_front()));
            end
            while (exp_acc_q.size() > 0 && exp_acc_q[0] < cyc)
                flag_error("en_acc_missed", exp_acc_q.pop_front());
            if (upd_done || upd_abort) begin
                if (exp_ev_q.size() == 0) flag_error("update_event_unexpected", int'({upd_abort, upd_done}));
                else begin
                    check("update_event", 64'({upd_abort, upd_done}), 64'(exp_ev_q.pop_front()));
                    check("loaded_at_event", 64'(loaded), 64'(upd_done & ~upd_abort));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(bit v);
        sample = v;
        if (v) begin
            if (in_run) begin
                exp_dly_q.push_back(cyc + 1);
                exp_acc_q.push_back(cyc + 2);
            end else begin
                drop_exp = (drop_exp < DROP_MAX) ? drop_exp + 1 : DROP_MAX;
            end
        end
        tick();
        sample = 1'b0;
    endtask

    // mode 0: full set, flag left high
    // mode 1: full set, flag falls with the final coefficient
    // mode 2: n taps then flag falls (abort)
    // mode 3: n taps then stop driving, flag left high
    task automatic load_set(int n, int mode, bit seq);
        logic [DATA_W-1:0] d;
        bit acc;
        int t;
        flag = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                cvalid = 1'b0;
                tick();
            end
            d = seq ? DATA_W'(i + 1) : DATA_W'($urandom);
            cvalid = 1'b1;
            cdata  = d;
            if (mode == 1 && i == NUM_TAPS - 1) flag = 1'b0;
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                acc = coeff_ready;
                tick();
                t++;
                if (!acc && t > 8) begin
                    flag_error("coeff_ready_timeout", i);
                    cvalid = 1'b0;
                    return;
                end
            end
            exp_wr_q.push_back({ADDR_W'(i), d});
        end
        cvalid = 1'b0;
        if (mode <= 1) begin
            exp_ev_q.push_back(EV_DONE);
            check("ready_low_after_last", 64'(coeff_ready), 64'(0));
        end else if (mode == 2) begin
            flag = 1'b0;
            exp_ev_q.push_back(EV_ABORT);
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive_sample(1'b0);
    endtask

    task automatic random_samples(int n);
        repeat (n) drive_sample(1'($urandom_range(0, 1)));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(84 * 20000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_csn", 64'(csn), 64'(1));
        check("rst_wrn", 64'(wrn), 64'(1));
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        check("rst_ready", 64'(coeff_ready), 64'(0));
        check("rst_loaded", 64'(loaded), 64'(0));
        check("rst_enables", 64'({en_delay, en_acc}), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        idle(2);

        // 1: sequential full load
        load_set(NUM_TAPS, 0, 1'b1);
        idle(3);
        check("t1_loaded", 64'(loaded), 64'(1));
        check("t1_state_run", 64'(dbg_state), 64'(ST_RUN));
        in_run = 1'b1;

        // 2: samples at offsets 0, 1, 5 then random traffic
        for (int c = 0; c < 8; c++) drive_sample(c == 0 || c == 1 || c == 5);
        random_samples(40);
        idle(3);
        check("t2_drop_unchanged", 64'(drop_cnt), 64'(drop_exp));
        flag = 1'b0;
        idle(2);

        // 3: abort after 10 taps, then samples are dropped
        in_run = 1'b0;
        load_set(10, 2, 1'b0);
        idle(2);
        check("t3_loaded_cleared", 64'(loaded), 64'(0));
        check("t3_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        random_samples(20);
        check("t3_drop_count", 64'(drop_cnt), 64'(drop_exp));

        // 4: final accept coincides with flag fall
        load_set(NUM_TAPS, 1, 1'b0);
        idle(3);
        check("t4_loaded", 64'(loaded), 64'(1));
        check("t4_state_run", 64'(dbg_state), 64'(ST_RUN));
        in_run = 1'b1;
        random_samples(20);
        idle(3);

        // 5: async reset mid-load after tap 20
        in_run = 1'b0;
        load_set(21, 3, 1'b0);
        @(negedge clk);
        #5;
        rst  = 1'b1;
        flag = 1'b0;
        drop_exp = 0;
        #1;
        check("t5_rst_csn_wrn", 64'({csn, wrn}), 64'(2'b11));
        check("t5_rst_addr_data", 64'({addr, wdata}), 64'(0));
        check("t5_rst_ready", 64'(coeff_ready), 64'(0));
        check("t5_rst_loaded", 64'(loaded), 64'(0));
        check("t5_rst_drop", 64'(drop_cnt), 64'(0));
        check("t5_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        tick();
        idle(5);
        random_samples(10);
        check("t5_drop_count", 64'(drop_cnt), 64'(drop_exp));
        load_set(NUM_TAPS, 0, 1'b0);
        idle(3);
        in_run = 1'b1;
        random_samples(20);
        idle(3);
        flag = 1'b0;
        idle(2);

        // 6: drop counter saturation in IDLE (loaded cleared by an abort)
        in_run = 1'b0;
        load_set(3, 2, 1'b0);
        idle(2);
        repeat (300) drive_sample(1'b1);
        check("t6_drop_saturated", 64'(drop_cnt), 64'(drop_exp));
        check("t6_state_idle", 64'(dbg_state), 64'(ST_IDLE));

        idle(4);
        check("left_sram_writes", 64'(exp_wr_q.size()), 64'(0));
        check("left_en_delay", 64'(exp_dly_q.size()), 64'(0));
        check("left_en_acc", 64'(exp_acc_q.size()), 64'(0));
        check("left_events", 64'(exp_ev_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
